// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU-drive and response signals of the ALU command issuer.
// The slave modport is the issuer's view; the master modport is the
// view of whatever surrounds it (command source, ALU and response sink).
interface alu_cmd_issuer_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  localparam int CNT_FW = $clog2(DEPTH) + 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_a;
  logic [3:0]        cmd_b;
  logic [2:0]        cmd_op;
  logic              cmd_mode;

  logic [3:0]        alu_a;
  logic [3:0]        alu_b;
  logic [2:0]        alu_op;
  logic              alu_mode;
  logic [3:0]        alu_result;
  logic              alu_overflow;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [3:0]        rsp_result;
  logic              rsp_overflow;
  logic [2:0]        rsp_op;

  logic [CNT_FW-1:0] fifo_count;
  logic [CNT_W-1:0]  ovf_count;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_mode,
    input  alu_result, alu_overflow,
    input  rsp_ready,
    output cmd_ready,
    output alu_a, alu_b, alu_op, alu_mode,
    output rsp_valid, rsp_result, rsp_overflow, rsp_op,
    output fifo_count, ovf_count
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_mode,
    output alu_result, alu_overflow,
    output rsp_ready,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op, alu_mode,
    input  rsp_valid, rsp_result, rsp_overflow, rsp_op,
    input  fifo_count, ovf_count
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Command-side front end for a 4-bit combinational ALU. Commands are
// buffered in a FIFO, issued one at a time through registered drive
// ports, and each result/overflow pair is returned in command order
// over a registered valid/ready response, with a saturating count of
// captured overflows.
module alu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  alu_cmd_issuer_if.slave   bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_FW = PTR_W + 1;
  localparam logic [CNT_FW-1:0] FULL    = CNT_FW'(DEPTH);
  localparam logic [CNT_W-1:0]  OVF_MAX = '1;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic       mode;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  cmd_t              mem_q [DEPTH];
  cmd_t              mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_FW-1:0] count_q, count_d;
  state_t            state_q, state_d;
  cmd_t              alu_q, alu_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [3:0]        rsp_result_q, rsp_result_d;
  logic              rsp_overflow_q, rsp_overflow_d;
  logic [2:0]        rsp_op_q, rsp_op_d;
  logic [CNT_W-1:0]  ovf_q, ovf_d;

  logic push;
  logic pop;
  logic empty;

  assign bus.cmd_ready    = (count_q != FULL);
  assign empty            = (count_q == '0);
  assign push             = bus.cmd_valid && bus.cmd_ready;

  assign bus.alu_a        = alu_q.a;
  assign bus.alu_b        = alu_q.b;
  assign bus.alu_op       = alu_q.op;
  assign bus.alu_mode     = alu_q.mode;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_overflow = rsp_overflow_q;
  assign bus.rsp_op       = rsp_op_q;
  assign bus.fifo_count   = count_q;
  assign bus.ovf_count    = ovf_q;

  // Issue sequencing: pop a command into the drive registers, give the ALU one cycle, capture, then hold until the consumer takes it.
  always_comb begin
    state_d        = state_q;
    pop            = 1'b0;
    alu_d          = alu_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_result_d   = rsp_result_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_op_d       = rsp_op_q;
    ovf_d          = ovf_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          alu_d   = mem_q[rd_ptr_q];
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        rsp_result_d   = bus.alu_result;
        rsp_overflow_d = bus.alu_overflow;
        rsp_op_d       = alu_q.op;
        rsp_valid_d    = 1'b1;
        if (bus.alu_overflow && (ovf_q != OVF_MAX)) begin
          ovf_d = ovf_q + CNT_W'(1);
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_valid_q && bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!empty) begin
            pop     = 1'b1;
            alu_d   = mem_q[rd_ptr_q];
            state_d = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping: write on accepted command, advance read on issue, occupancy follows both.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op, mode: bus.cmd_mode};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_FW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_FW'(1);
    end
  end

  // Command storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      state_q        <= IDLE;
      alu_q          <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_op_q       <= '0;
      ovf_q          <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      state_q        <= state_d;
      alu_q          <= alu_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_op_q       <= rsp_op_d;
      ovf_q          <= ovf_d;
    end
  end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer. A behavioural 4-bit ALU sits
// on the drive ports; every accepted command is turned into its expected
// response and queued, and every response handshake is recorded, so the
// tests compare the response stream against command order.
module tb_alu_cmd_issuer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_cyc[$];

  alu_cmd_issuer_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  alu_cmd_issuer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {overflow, result}.
  function automatic logic [4:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op, input logic mode);
    logic [4:0] s;
    logic [3:0] r;
    logic       v;
    s = '0;
    r = '0;
    v = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; v = mode ? (a[3] == b[3] && r[3] != a[3]) : s[4]; end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; v = mode ? (a[3] != b[3] && r[3] != a[3]) : s[4]; end
      3'd2: begin r = a << 1; v = mode ? (r[3] != a[3]) : a[3]; end
      3'd3: begin r = a >> 1; end
      3'd4: begin r = {a[3], a[3:1]}; end
      3'd5: begin r = -a; v = mode ? (a == 4'b1000) : (a != 4'd0); end
      3'd6: begin
        if (a == b) r = 4'd0;
        else if (mode ? ($signed(a) < $signed(b)) : (a < b)) r = 4'b1111;
        else r = 4'd1;
      end
      default: r = 4'd0;
    endcase
    return {v, r};
  endfunction

  // Expected response word: {result, overflow, op}.
  function automatic logic [7:0] expect_of(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op, input logic mode);
    logic [4:0] r;
    r = alu_fn(a, b, op, mode);
    return {r[3:0], r[4], op};
  endfunction

  assign {bus.alu_overflow, bus.alu_result} = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_mode);

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model of ordering: accepted commands queue their expected response; handshakes record what came out.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      got_q.delete();
      got_cyc.delete();
    end else begin
      if (bus.cmd_valid && bus.cmd_ready)
        exp_q.push_back(expect_of(bus.cmd_a, bus.cmd_b, bus.cmd_op, bus.cmd_mode));
      if (bus.rsp_valid && bus.rsp_ready) begin
        got_q.push_back({bus.rsp_result, bus.rsp_overflow, bus.rsp_op});
        got_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_cmd(input logic [11:0] c);
    {bus.cmd_a, bus.cmd_b, bus.cmd_op, bus.cmd_mode} = c;
  endtask

  task automatic push_cmd(input logic [11:0] c);
    int budget;
    budget = 0;
    set_cmd(c);
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && budget < 60) begin
      step();
      budget++;
    end
    if (budget >= 60) begin
      checks++;
      errors++;
      $display("[TB] FAIL push_timeout cmd_ready=%b required 1", bus.cmd_ready);
    end
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (got_q.size() < n && k < budget) begin
      step();
      k++;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready got %b exp 1", bus.cmd_ready); end
    checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_overflow, bus.rsp_op} !== 9'd0) begin
      errors++; $display("[TB] FAIL reset_rsp got %h exp 0", {bus.rsp_valid, bus.rsp_result, bus.rsp_overflow, bus.rsp_op});
    end
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_mode} !== 12'd0) begin
      errors++; $display("[TB] FAIL reset_alu got %h exp 0", {bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_mode});
    end
    checks++;
    if ({bus.fifo_count, bus.ovf_count} !== '0) begin
      errors++; $display("[TB] FAIL reset_counts got %h exp 0", {bus.fifo_count, bus.ovf_count});
    end
  endtask

  task automatic test_single();
    bus.rsp_ready = 1'b0;
    set_cmd({4'b1101, 4'b0111, 3'b000, 1'b1});
    bus.cmd_valid = 1'b1;
    step();
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.fifo_count !== 3'd1) begin
      errors++; $display("[TB] FAIL single_accept valid=%b count=%0d exp 0/1", bus.rsp_valid, bus.fifo_count);
    end
    step();
    checks++;
    if (bus.alu_a !== 4'b1101 || bus.alu_b !== 4'b0111 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL single_issue alu_a=%b alu_b=%b valid=%b exp 1101/0111/0", bus.alu_a, bus.alu_b, bus.rsp_valid);
    end
    step();
    checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_overflow, bus.rsp_op} !== {1'b1, 4'b0100, 1'b0, 3'b000}) begin
      errors++; $display("[TB] FAIL single_capture got %b exp 1_0100_0_000", {bus.rsp_valid, bus.rsp_result, bus.rsp_overflow, bus.rsp_op});
    end
    bus.rsp_ready = 1'b1;
    step();
    checks++;
    if (bus.rsp_valid !== 1'b0 || got_q.size() != 1) begin
      errors++; $display("[TB] FAIL single_handshake valid=%b responses=%0d exp 0/1", bus.rsp_valid, got_q.size());
    end
    clear_queues();
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    bus.rsp_ready = 1'b1;
    push_cmd({4'b0111, 4'b0001, 3'b000, 1'b1});
    push_cmd({4'b0111, 4'b1111, 3'b001, 1'b1});
    wait_got(2, 30, ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL ovf_responses got %0d exp 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 8'b1000_1_000) begin errors++; $display("[TB] FAIL ovf_add got %b exp 10001000", got_q[0]); end
      checks++;
      if (got_q[1] !== 8'b1000_1_001) begin errors++; $display("[TB] FAIL ovf_sub got %b exp 10001001", got_q[1]); end
    end
    checks++;
    if (bus.ovf_count !== 8'd2) begin errors++; $display("[TB] FAIL ovf_count got %0d exp 2", bus.ovf_count); end
    clear_queues();
  endtask

  task automatic test_fill();
    logic [11:0] cmds [DEPTH+2];
    int idx;
    int budget;
    bit acc;
    for (int i = 0; i < DEPTH + 2; i++)
      cmds[i] = {4'(i + 3), 4'($urandom), 3'(i), 1'($urandom)};
    bus.rsp_ready = 1'b0;
    idx = 0;
    for (int t = 0; t < 12; t++) begin
      if (idx < DEPTH + 2) begin set_cmd(cmds[idx]); bus.cmd_valid = 1'b1; end
      else bus.cmd_valid = 1'b0;
      acc = bus.cmd_valid && bus.cmd_ready;
      step();
      if (acc) idx++;
    end
    checks++;
    if (idx != DEPTH + 1 || bus.fifo_count !== 3'(DEPTH) || bus.cmd_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL fill_full accepted=%0d count=%0d ready=%b exp %0d/%0d/0", idx, bus.fifo_count, bus.cmd_ready, DEPTH + 1, DEPTH);
    end
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_op !== cmds[0][3:1]) begin
      errors++; $display("[TB] FAIL fill_held valid=%b op=%b exp 1/%b", bus.rsp_valid, bus.rsp_op, cmds[0][3:1]);
    end
    bus.rsp_ready = 1'b1;
    budget = 0;
    while ((idx < DEPTH + 2 || got_q.size() < DEPTH + 2) && budget < 80) begin
      if (idx < DEPTH + 2) begin set_cmd(cmds[idx]); bus.cmd_valid = 1'b1; end
      else bus.cmd_valid = 1'b0;
      acc = bus.cmd_valid && bus.cmd_ready;
      step();
      if (acc) idx++;
      budget++;
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (got_q.size() != DEPTH + 2 || exp_q.size() != DEPTH + 2) begin
      errors++; $display("[TB] FAIL fill_drain_count got %0d exp %0d", got_q.size(), DEPTH + 2);
    end else begin
      for (int k = 0; k < DEPTH + 2; k++) begin
        checks++;
        if (got_q[k] !== exp_q[k] || got_q[k][2:0] !== cmds[k][3:1]) begin
          errors++; $display("[TB] FAIL fill_order[%0d] got %b exp %b", k, got_q[k], exp_q[k]);
        end
      end
    end
    clear_queues();
  endtask

  task automatic test_backpressure();
    logic [7:0]  rsnap;
    logic [11:0] asnap;
    int budget;
    bit ok;
    bus.rsp_ready = 1'b0;
    push_cmd({4'b0011, 4'b0101, 3'b001, 1'b0});
    push_cmd({4'b1001, 4'b0010, 3'b000, 1'b0});
    budget = 0;
    while (!bus.rsp_valid && budget < 10) begin step(); budget++; end
    checks++;
    if (bus.rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid got %b exp 1", bus.rsp_valid); end
    rsnap = {bus.rsp_result, bus.rsp_overflow, bus.rsp_op};
    asnap = {bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_mode};
    for (int t = 0; t < 5; t++) begin
      step();
      checks++;
      if (bus.rsp_valid !== 1'b1 || {bus.rsp_result, bus.rsp_overflow, bus.rsp_op} !== rsnap ||
          {bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_mode} !== asnap) begin
        errors++; $display("[TB] FAIL bp_stable[%0d] rsp=%b alu=%h exp %b/%h", t,
                           {bus.rsp_result, bus.rsp_overflow, bus.rsp_op}, {bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_mode}, rsnap, asnap);
      end
    end
    checks++;
    if (rsnap !== expect_of(4'b0011, 4'b0101, 3'b001, 1'b0)) begin
      errors++; $display("[TB] FAIL bp_first got %b exp %b", rsnap, expect_of(4'b0011, 4'b0101, 3'b001, 1'b0));
    end
    bus.rsp_ready = 1'b1;
    step();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.alu_a !== 4'b1001) begin
      errors++; $display("[TB] FAIL bp_next_issue valid=%b alu_a=%b exp 0/1001", bus.rsp_valid, bus.alu_a);
    end
    wait_got(2, 10, ok);
    checks++;
    if (!ok || got_q[1] !== expect_of(4'b1001, 4'b0010, 3'b000, 1'b0)) begin
      errors++; $display("[TB] FAIL bp_second responses=%0d exp 2", got_q.size());
    end
    clear_queues();
  endtask

  task automatic test_stream();
    logic [3:0] exp_res [4];
    bit ok;
    exp_res[0] = 4'b0100;
    exp_res[1] = 4'b0101;
    exp_res[2] = 4'b1101;
    exp_res[3] = 4'b0110;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_cmd({4'b1010, 4'($urandom), 3'(i + 2), 1'b0});
    wait_got(4, 20, ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL stream_count got %0d exp 4", got_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got_q[k][7:4] !== exp_res[k] || got_q[k][2:0] !== 3'(k + 2)) begin
          errors++; $display("[TB] FAIL stream_result[%0d] got %b exp %b", k, got_q[k][7:4], exp_res[k]);
        end
        if (k > 0) begin
          checks++;
          if (got_cyc[k] - got_cyc[k-1] != 2) begin
            errors++; $display("[TB] FAIL stream_rate[%0d] got %0d exp 2", k, got_cyc[k] - got_cyc[k-1]);
          end
        end
      end
    end
    clear_queues();
  endtask

  task automatic test_reset_mid();
    int budget;
    bit stale;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_cmd({4'(i + 1), 4'(i), 3'(i), 1'b1});
    budget = 0;
    while (!(bus.rsp_valid && bus.fifo_count == 3'd3) && budget < 10) begin step(); budget++; end
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.fifo_count !== 3'd3) begin
      errors++; $display("[TB] FAIL rmid_setup valid=%b count=%0d exp 1/3", bus.rsp_valid, bus.fifo_count);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.rsp_result, bus.rsp_overflow, bus.rsp_op, bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_mode} !== 21'd0 ||
        {bus.fifo_count, bus.ovf_count} !== '0 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL rmid_values valid=%b count=%0d ovf=%0d ready=%b exp 0/0/0/1",
                         bus.rsp_valid, bus.fifo_count, bus.ovf_count, bus.cmd_ready);
    end
    bus.rsp_ready = 1'b1;
    stale = 1'b0;
    for (int t = 0; t < 6; t++) begin
      step();
      if (bus.rsp_valid !== 1'b0 || bus.fifo_count !== 3'd0) stale = 1'b1;
    end
    checks++;
    if (stale || got_q.size() != 0) begin
      errors++; $display("[TB] FAIL rmid_stale responses=%0d exp 0", got_q.size());
    end
    clear_queues();
  endtask

  task automatic test_saturation();
    bit ok;
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 260; i++) push_cmd({4'b0111, 4'b0001, 3'b000, 1'b1});
    wait_got(260, 40, ok);
    checks++;
    if (!ok || bus.ovf_count !== 8'd255) begin
      errors++; $display("[TB] FAIL ovf_saturate got %0d exp 255 (responses %0d)", bus.ovf_count, got_q.size());
    end
    clear_queues();
  endtask

  task automatic test_random();
    logic [7:0] prev_data;
    bit prev_stall;
    bit ok;
    int ovf_sum;
    do_reset();
    for (int t = 0; t < 500; t++) begin
      set_cmd(12'($urandom));
      bus.cmd_valid = ($urandom_range(0, 9) < 6);
      bus.rsp_ready = ($urandom_range(0, 9) < 5);
      prev_stall = bus.rsp_valid && !bus.rsp_ready;
      prev_data  = {bus.rsp_result, bus.rsp_overflow, bus.rsp_op};
      step();
      if (prev_stall) begin
        checks++;
        if (bus.rsp_valid !== 1'b1 || {bus.rsp_result, bus.rsp_overflow, bus.rsp_op} !== prev_data) begin
          errors++; $display("[TB] FAIL rand_hold[%0d] valid=%b data=%b exp 1/%b", t, bus.rsp_valid,
                             {bus.rsp_result, bus.rsp_overflow, bus.rsp_op}, prev_data);
        end
      end
      checks++;
      if (bus.fifo_count > 3'(DEPTH) || bus.cmd_ready !== (bus.fifo_count != 3'(DEPTH))) begin
        errors++; $display("[TB] FAIL rand_count[%0d] count=%0d ready=%b", t, bus.fifo_count, bus.cmd_ready);
      end
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_got(exp_q.size(), 40, ok);
    checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL rand_drain got %0d exp %0d", got_q.size(), exp_q.size());
    end else begin
      ovf_sum = 0;
      for (int k = 0; k < exp_q.size(); k++) begin
        ovf_sum += int'(exp_q[k][3]);
        checks++;
        if (got_q[k] !== exp_q[k]) begin
          errors++; $display("[TB] FAIL rand_order[%0d] got %b exp %b", k, got_q[k], exp_q[k]);
        end
      end
      checks++;
      if (bus.ovf_count !== CNT_W'((ovf_sum > 255) ? 255 : ovf_sum)) begin
        errors++; $display("[TB] FAIL rand_ovf_count got %0d exp %0d", bus.ovf_count, (ovf_sum > 255) ? 255 : ovf_sum);
      end
    end
    clear_queues();
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_op    = '0;
    bus.cmd_mode  = 1'b0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_fill();
    test_backpressure();
    test_stream();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end
endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Command-side front end for the 4-bit combinational ALU. It accepts ALU commands (A, B, op, mode) over a valid/ready handshake and buffers them in a small FIFO. Commands are issued to the ALU one at a time through registered drive ports. Each ALU result and overflow flag is captured and returned over a second valid/ready handshake, strictly in command order, together with a saturating overflow counter.

## Interface
Parameters:
- DEPTH, 4, command FIFO depth; power of two, ≥2
- CNT_W, 8, width of overflow counter

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- cmd_valid  input  1  command offered
- cmd_ready  output  1  FIFO can accept (= not full)
- cmd_a  input  4  operand A
- cmd_b  input  4  operand B
- cmd_op  input  3  ALU op code: 000 add, 001 sub, 010 shl, 011 shr, 100 ashr, 101 neg, 110 compare, 111 zero
- cmd_mode  input  1  0 unsigned, 1 signed
- alu_a  output  4  registered drive to ALU A
- alu_b  output  4  registered drive to ALU B
- alu_op  output  3  registered drive to ALU op
- alu_mode  output  1  registered drive to ALU mode
- alu_result  input  4  ALU Result
- alu_overflow  input  1  ALU overflow
- rsp_valid  output  1  response available
- rsp_ready  input  1  consumer accepts response
- rsp_result  output  4  captured result
- rsp_overflow  output  1  captured overflow
- rsp_op  output  3  op code of the responded command
- fifo_count  output  $clog2(DEPTH)+1  entries currently buffered
- ovf_count  output  CNT_W  number of captured overflows, saturating

## Operation
- FIFO:
  - Push on cmd_valid & cmd_ready. Pop only by the FSM.
  - Push and pop in the same cycle are both performed; fifo_count is unchanged.
  - Pointers wrap modulo DEPTH.
  - cmd_ready is low when fifo_count == DEPTH, even if a pop happens that cycle.
- FSM states: IDLE, DRIVE, RESP.
  - IDLE: if FIFO is non-empty, pop the head into alu_* registers → DRIVE. Otherwise stay.
  - DRIVE: sample alu_result/alu_overflow into rsp_result/rsp_overflow, copy alu_op into rsp_op, set rsp_valid → RESP.
  - RESP: hold all rsp_* stable while rsp_valid & !rsp_ready.
    - On handshake with FIFO non-empty: pop the next head into alu_*, clear rsp_valid → DRIVE.
    - On handshake with FIFO empty: clear rsp_valid → IDLE.
- alu_* hold their last issued value outside DRIVE. They are never changed while in DRIVE.
- ovf_count increments by 1 on the DRIVE capture edge when alu_overflow = 1. It saturates at 2^CNT_W−1 with no wrap.
- Op 111 and every other op code are passed through unchanged. The issuer never interprets op, mode, or results.
- Ordering: responses come out in exactly FIFO order; no command is dropped or duplicated.

## Timing
- Reset values:
  - cmd_ready = 1, rsp_valid = 0, rsp_result = 0, rsp_overflow = 0, rsp_op = 0
  - alu_a = alu_b = 0, alu_op = 0, alu_mode = 0
  - fifo_count = 0, ovf_count = 0, state IDLE
- Reset mid-operation empties the FIFO and discards any in-flight or pending response. The cycle after rst deasserts behaves as post-reset.
- Latency, empty and IDLE:
  - Command accepted at edge N.
  - Popped to alu_* at edge N+1.
  - Captured at edge N+2, so rsp_valid is high from N+2.
- The ALU gets one full cycle (DRIVE) to settle before capture.
- Throughput: with rsp_ready held high and the FIFO non-empty, one response every 2 cycles.
- Response is a registered handshake:
  - rsp_valid never drops without rsp_ready.
  - rsp_* do not change while rsp_valid & !rsp_ready.
- fifo_count and cmd_ready are registered and reflect pushes/pops of the previous edge.

## Test plan
- Reset then single command (a=1101, b=0111, op=000, mode=1) → rsp_valid 2 cycles after acceptance, rsp_result=0100, rsp_overflow=0, rsp_op=000.
- Signed add overflow (a=0111, b=0001, op=000, mode=1), then signed sub (a=0111, b=1111, op=001, mode=1) → results 1000/ovf 1 and 1000/ovf 1 in order; ovf_count=2.
- Fill: rsp_ready=0, push DEPTH+2 commands → cmd_ready low once fifo_count=DEPTH with one command held in RESP. No further push is accepted. Releasing rsp_ready drains all responses in order, with matching rsp_op values.
- Backpressure: stall rsp_ready for 5 cycles with rsp_valid high → rsp_* stable; the next op is not issued until the handshake.
- Streaming with rsp_ready=1 and continuous cmd_valid (ops 010, 011, 100, 101 on a=1010) → responses 0100, 0101, 1101, 0110 at a one-per-2-cycle rate.
- Assert rst for 1 cycle while in RESP with 3 entries queued → all outputs return to reset values; no stale response after rst.
